nibble_packer: RTL and testbench

//  Inverse of the display-side nibble selector: collects 4-bit digits (keypad/serial entry) one per

---
 rtl/nibble_pkg.sv | 18 +
 rtl/nibble_packer.sv | 106 ++++++++++
 tb/tb_nibble_packer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/nibble_pkg.sv
// Shared sizing for the nibble packer: default nibble width and count,
// plus the derived slot-index and word widths used by the packer and its users.
package nibble_pkg;

  // Default digit width and digits per word
  localparam int W_DEF       = 4;
  localparam int NIBBLES_DEF = 4;

  // Derived widths for the default configuration
  localparam int IDX_W  = $clog2(NIBBLES_DEF);
  localparam int WORD_W = NIBBLES_DEF * W_DEF;

  // Slot-index width for an arbitrary nibble count; never narrower than one bit
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nibble_packer.sv
// Nibble packer: gathers W-bit digits one per valid/ready handshake into a
// NIBBLES*W word and presents it on a one-deep valid/ready output buffer.
// The digit counter is the only sequencing state; the output buffer lets a
// new word complete in the same cycle the previous one is taken, so the
// packer sustains one nibble per clock.
module nibble_packer
  import nibble_pkg::*;
#(
  parameter int W         = W_DEF,
  parameter int NIBBLES   = NIBBLES_DEF,
  parameter bit MSB_FIRST = 1'b0,
  localparam int IDX_BITS  = idx_width(NIBBLES),
  localparam int WORD_BITS = NIBBLES * W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic [W-1:0]         in_nib,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [IDX_BITS-1:0]  nib_idx,
  output logic [WORD_BITS-1:0] out_word,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NIBBLES - 1);

  // Sequencing and storage registers
  logic [IDX_BITS-1:0]  r_cnt;    // accepted nibbles of the word under assembly
  logic [WORD_BITS-1:0] r_asm;    // word under assembly
  logic [WORD_BITS-1:0] r_word;   // completed word presented to the consumer
  logic                 r_valid;  // r_word not yet taken

  // Combinational helpers
  logic                 w_last;      // next accepted nibble completes the word
  logic                 w_take;      // consumer takes the pending word this cycle
  logic                 w_stall;     // completion must wait for the pending word
  logic                 w_accept;    // nibble handshake this cycle
  logic                 w_complete;  // last nibble accepted this cycle
  logic [IDX_BITS-1:0]  w_slot;      // physical slot the next nibble fills
  logic [NIBBLES-1:0]   w_slot_hit;  // one-hot write enable per slot
  logic [WORD_BITS-1:0] w_asm_next;  // assembly word with this cycle's nibble merged

  assign w_last     = (r_cnt == LAST_IDX);
  assign w_take     = r_valid & out_ready;
  // Only the completing nibble needs buffer space; earlier nibbles go into
  // the assembly register, which is always free.
  assign w_stall    = w_last & r_valid & ~out_ready;
  assign in_ready   = ~clear & ~w_stall;
  assign w_accept   = in_valid & in_ready;
  assign w_complete = w_accept & w_last;

  // MSB-first mode fills from the top slot downwards
  assign w_slot  = MSB_FIRST ? (LAST_IDX - r_cnt) : r_cnt;
  assign nib_idx = w_slot;

  // Per-slot merge: a slot takes in_nib only on an accepted handshake that
  // targets it, so an undriven in_nib while idle never reaches the registers.
  genvar gi;
  generate
    for (gi = 0; gi < NIBBLES; gi++) begin : g_slot
      localparam logic [IDX_BITS-1:0] SLOT = IDX_BITS'(gi);
      assign w_slot_hit[gi]       = w_accept & (w_slot == SLOT);
      assign w_asm_next[gi*W +: W] = w_slot_hit[gi] ? in_nib : r_asm[gi*W +: W];
    end
  endgenerate

  // Digit counter and assembly register: advance on accept, restart on clear
  // or after the last digit of a word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_asm <= '0;
    end else if (clear) begin
      r_cnt <= '0;
      r_asm <= '0;
    end else if (w_accept) begin
      if (w_last) begin
        r_cnt <= '0;
        r_asm <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
        r_asm <= w_asm_next;
      end
    end
  end

  // Output buffer: load on completion (even while the old word is being
  // taken), drop valid only on a take with nothing new; clear leaves it alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word  <= '0;
      r_valid <= 1'b0;
    end else if (w_complete) begin
      r_word  <= w_asm_next;
      r_valid <= 1'b1;
    end else if (w_take) begin
      r_valid <= 1'b0;
    end
  end

  assign out_word  = r_word;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_nibble_packer.sv
// Directed bench for nibble_packer: an LSB-first and an MSB-first instance
// share one stimulus stream; a cycle table covers fill, back-to-back words,
// output stall, take+complete in one cycle and clear, followed by hand-written
// asynchronous reset sequences.
module tb_nibble_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic [3:0]  in_nib = 4'h0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready_l, in_ready_m;
  logic [1:0]  nib_idx_l, nib_idx_m;
  logic [15:0] out_word_l, out_word_m;
  logic        out_valid_l, out_valid_m;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nibble_packer #(.W(4), .NIBBLES(4), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_nib(in_nib), .in_valid(in_valid),
    .in_ready(in_ready_l), .nib_idx(nib_idx_l), .out_word(out_word_l),
    .out_valid(out_valid_l), .out_ready(out_ready)
  );

  nibble_packer #(.W(4), .NIBBLES(4), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_nib(in_nib), .in_valid(in_valid),
    .in_ready(in_ready_m), .nib_idx(nib_idx_m), .out_word(out_word_m),
    .out_valid(out_valid_m), .out_ready(out_ready)
  );

  typedef struct {
    logic        v;
    logic [3:0]  n;
    logic        r;
    logic        c;
    logic        e_rdy;
    logic [1:0]  e_idx;   // LSB-first slot; MSB-first expects 3-e_idx
    logic        e_ov;
    logic [15:0] e_ow;    // LSB-first word; MSB-first expects nibble-reversed
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic [3:0] n, input logic r, input logic c,
                     input logic e_rdy, input logic [1:0] e_idx, input logic e_ov,
                     input logic [15:0] e_ow);
    vec_t t;
    t.v = v; t.n = n; t.r = r; t.c = c;
    t.e_rdy = e_rdy; t.e_idx = e_idx; t.e_ov = e_ov; t.e_ow = e_ow;
    vecs.push_back(t);
  endtask

  function automatic logic [15:0] rev16(input logic [15:0] w);
    return {w[3:0], w[7:4], w[11:8], w[15:12]};
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%h required=%h", name, row, act, exp);
    end
  endtask

  // Check both instances against the LSB-first expectation and its mirror
  task automatic chk_all(input int row, input logic e_rdy, input logic [1:0] e_idx,
                         input logic e_ov, input logic [15:0] e_ow);
    logic [1:0] m_idx;
    m_idx = 2'd3 - e_idx;
    chk("in_ready_lsb",  row, {31'd0, in_ready_l},  {31'd0, e_rdy});
    chk("nib_idx_lsb",   row, {30'd0, nib_idx_l},   {30'd0, e_idx});
    chk("out_valid_lsb", row, {31'd0, out_valid_l}, {31'd0, e_ov});
    chk("out_word_lsb",  row, {16'd0, out_word_l},  {16'd0, e_ow});
    chk("in_ready_msb",  row, {31'd0, in_ready_m},  {31'd0, e_rdy});
    chk("nib_idx_msb",   row, {30'd0, nib_idx_m},   {30'd0, m_idx});
    chk("out_valid_msb", row, {31'd0, out_valid_m}, {31'd0, e_ov});
    chk("out_word_msb",  row, {16'd0, out_word_m},  {16'd0, rev16(e_ow)});
    $display("row %0d v=%0b nib=%h rdy=%0b idx=%0d ov=%0b word=%h msb_word=%h",
             row, in_valid, in_nib, in_ready_l, nib_idx_l, out_valid_l, out_word_l, out_word_m);
  endtask

  task automatic drive(input logic v, input logic [3:0] n, input logic r, input logic c);
    @(negedge clk);
    in_valid = v; in_nib = n; out_ready = r; clear = c;
  endtask

  initial begin
    // Each row: inputs for the cycle, then the expected state/handshake seen
    // before that cycle's rising edge.
    //    v  n     r  c   rdy idx ov word
    // 1..8 continuous, consumer always ready
    add(1, 4'h1, 1, 0,  1, 0, 0, 16'h0000);
    add(1, 4'h2, 1, 0,  1, 1, 0, 16'h0000);
    add(1, 4'h3, 1, 0,  1, 2, 0, 16'h0000);
    add(1, 4'h4, 1, 0,  1, 3, 0, 16'h0000);
    add(1, 4'h5, 1, 0,  1, 0, 1, 16'h4321);
    add(1, 4'h6, 1, 0,  1, 1, 0, 16'h4321);
    add(1, 4'h7, 1, 0,  1, 2, 0, 16'h4321);
    add(1, 4'h8, 1, 0,  1, 3, 0, 16'h4321);
    add(0, 4'hx, 1, 0,  1, 0, 1, 16'h8765);
    add(0, 4'hx, 1, 0,  1, 0, 0, 16'h8765);
    // word pending with consumer stalled: last nibble waits, then completes on the take
    add(1, 4'h1, 0, 0,  1, 0, 0, 16'h8765);
    add(1, 4'h2, 0, 0,  1, 1, 0, 16'h8765);
    add(1, 4'h3, 0, 0,  1, 2, 0, 16'h8765);
    add(1, 4'h4, 0, 0,  1, 3, 0, 16'h8765);
    add(1, 4'h5, 0, 0,  1, 0, 1, 16'h4321);
    add(1, 4'h6, 0, 0,  1, 1, 1, 16'h4321);
    add(1, 4'h7, 0, 0,  1, 2, 1, 16'h4321);
    add(1, 4'h8, 0, 0,  0, 3, 1, 16'h4321);
    add(1, 4'h8, 0, 0,  0, 3, 1, 16'h4321);
    add(1, 4'h8, 1, 0,  1, 3, 1, 16'h4321);
    add(0, 4'hx, 0, 0,  1, 0, 1, 16'h8765);
    add(0, 4'hx, 0, 0,  1, 0, 1, 16'h8765);
    add(0, 4'hx, 1, 0,  1, 0, 1, 16'h8765);
    add(0, 4'hx, 0, 0,  1, 0, 0, 16'h8765);
    // clear aborts a partial word; nibble offered with clear is refused
    add(1, 4'h1, 1, 0,  1, 0, 0, 16'h8765);
    add(1, 4'h2, 1, 0,  1, 1, 0, 16'h8765);
    add(1, 4'h9, 1, 1,  0, 2, 0, 16'h8765);
    add(1, 4'h5, 1, 0,  1, 0, 0, 16'h8765);
    add(1, 4'h6, 1, 0,  1, 1, 0, 16'h8765);
    add(1, 4'h7, 1, 0,  1, 2, 0, 16'h8765);
    add(1, 4'h8, 0, 0,  1, 3, 0, 16'h8765);
    // clear while a word is pending leaves it deliverable
    add(0, 4'hx, 0, 1,  0, 0, 1, 16'h8765);
    add(0, 4'hx, 1, 0,  1, 0, 1, 16'h8765);
    add(0, 4'hx, 0, 0,  1, 0, 0, 16'h8765);

    // Reset state, held in reset
    @(negedge clk);
    #1 chk_all(-1, 1'b1, 2'd0, 1'b0, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      in_valid = vecs[i].v; in_nib = vecs[i].n; out_ready = vecs[i].r; clear = vecs[i].c;
      #1 chk_all(i, vecs[i].e_rdy, vecs[i].e_idx, vecs[i].e_ov, vecs[i].e_ow);
    end

    // Reset mid-word: partial count discarded without waiting for a clock
    drive(1, 4'h1, 1, 0);
    drive(1, 4'h2, 1, 0);
    drive(0, 4'h0, 1, 0);
    #1 chk_all(100, 1'b1, 2'd2, 1'b0, 16'h8765);
    #1 rst_n = 1'b0;
    #1 chk_all(101, 1'b1, 2'd0, 1'b0, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset with a word pending: valid and word dropped without a clock
    drive(1, 4'h5, 0, 0);
    drive(1, 4'h6, 0, 0);
    drive(1, 4'h7, 0, 0);
    drive(1, 4'h8, 0, 0);
    drive(0, 4'h0, 0, 0);
    #1 chk_all(102, 1'b1, 2'd0, 1'b1, 16'h8765);
    #1 rst_n = 1'b0;
    #1 chk_all(103, 1'b1, 2'd0, 1'b0, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Fresh word after reset starts at slot 0
    drive(1, 4'h1, 1, 0);
    #1 chk_all(104, 1'b1, 2'd0, 1'b0, 16'h0000);
    drive(1, 4'h2, 1, 0);
    drive(1, 4'h3, 1, 0);
    drive(1, 4'h4, 1, 0);
    #1 chk_all(105, 1'b1, 2'd3, 1'b0, 16'h0000);
    drive(0, 4'h0, 1, 0);
    #1 chk_all(106, 1'b1, 2'd0, 1'b1, 16'h4321);
    drive(0, 4'h0, 0, 0);
    #1 chk_all(107, 1'b1, 2'd0, 1'b0, 16'h4321);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
